// File: rtl/stone_drawer_if.sv
// Stone drawer bus: start/quantity command, shared-RAM read port and VGA pixel write stream.
// master is the drawer itself, slave is the controller/RAM/VGA side.
interface stone_drawer_if;
    logic        start;
    logic [3:0]  quantity;
    logic [31:0] stone_data;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic        plot;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [8:0]  colour;
    logic        done;

    modport master (
        input  start, quantity, stone_data,
        output draw_stone_flag, draw_index, plot, vga_x, vga_y, colour, done
    );

    modport slave (
        output start, quantity, stone_data,
        input  draw_stone_flag, draw_index, plot, vga_x, vga_y, colour, done
    );
endinterface

// File: rtl/stone_drawer.sv
// Stone renderer: per entry 3 fetch cycles, +256 erase, +256 draw, +1 advance; done one cycle after the last entry.
// No backpressure: one pixel per cycle, start is dropped unless idle.
module stone_drawer #(
    parameter logic [8:0] COL_STONE   = 9'b100_100_100,
    parameter logic [8:0] COL_GOLD    = 9'b111_110_000,
    parameter logic [8:0] COL_DIAMOND = 9'b000_111_111,
    parameter logic [8:0] COL_BG      = 9'b011_010_001
) (
    input  logic           clock,
    input  logic           resetn,
    stone_drawer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_ERASE, S_DRAW, S_NEXT, S_DONE
    } state_t;

    state_t      state;
    logic [3:0]  qreg;
    logic [3:0]  idx;
    logic [7:0]  pc;
    logic [8:0]  cur_x;
    logic [7:0]  cur_y;
    logic [1:0]  cur_type;
    logic        cur_vis;

    // Where each stone was last drawn, so it can be erased when it moves or vanishes.
    logic [15:0] sh_v;
    logic [8:0]  sh_x [16];
    logic [7:0]  sh_y [16];

    logic        erase_needed;
    logic [8:0]  type_col;
    logic        emit;
    logic [8:0]  emit_x;
    logic [7:0]  emit_y;
    logic [7:0]  emit_pc;
    logic [8:0]  emit_col;
    logic [9:0]  sum_x;
    logic [9:0]  sum_y;
    logic        in_view;
    logic        unused_bits;

    assign erase_needed = sh_v[idx] & (~cur_vis | (sh_x[idx] != cur_x) | (sh_y[idx] != cur_y));

    always_comb begin
        case (cur_type)
            2'b00:   type_col = COL_STONE;
            2'b01:   type_col = COL_GOLD;
            default: type_col = COL_DIAMOND;
        endcase
    end

    // Pixel to present next cycle: first pixel of a box on entry, then pc+1 while scanning.
    always_comb begin
        emit     = 1'b0;
        emit_x   = cur_x;
        emit_y   = cur_y;
        emit_pc  = 8'd0;
        emit_col = type_col;
        case (state)
            S_LATCH: begin
                if (erase_needed) begin
                    emit     = 1'b1;
                    emit_x   = sh_x[idx];
                    emit_y   = sh_y[idx];
                    emit_col = COL_BG;
                end else if (cur_vis) begin
                    emit = 1'b1;
                end
            end
            S_ERASE: begin
                if (pc != 8'hFF) begin
                    emit     = 1'b1;
                    emit_x   = sh_x[idx];
                    emit_y   = sh_y[idx];
                    emit_pc  = pc + 8'd1;
                    emit_col = COL_BG;
                end else if (cur_vis) begin
                    emit = 1'b1;
                end
            end
            S_DRAW: begin
                if (pc != 8'hFF) begin
                    emit    = 1'b1;
                    emit_pc = pc + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign sum_x   = {1'b0, emit_x} + {6'd0, emit_pc[3:0]};
    assign sum_y   = {2'd0, emit_y} + {6'd0, emit_pc[7:4]};
    assign in_view = (sum_x < 10'd320) && (sum_y < 10'd240);

    assign unused_bits = ^{bus.stone_data[22:19], bus.stone_data[10:4], bus.stone_data[0],
                           sum_x[9], sum_y[9:8]};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state               <= S_IDLE;
            qreg                <= 4'd0;
            idx                 <= 4'd0;
            pc                  <= 8'd0;
            cur_x               <= 9'd0;
            cur_y               <= 8'd0;
            cur_type            <= 2'd0;
            cur_vis             <= 1'b0;
            sh_v                <= 16'd0;
            bus.draw_stone_flag <= 1'b0;
            bus.draw_index      <= 4'd0;
            bus.plot            <= 1'b0;
            bus.vga_x           <= 9'd0;
            bus.vga_y           <= 8'd0;
            bus.colour          <= 9'd0;
            bus.done            <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.plot <= 1'b0;
            if (emit) begin
                // Clipped pixels still advance the scan; only plot and colour are suppressed.
                bus.plot  <= in_view;
                bus.vga_x <= sum_x[8:0];
                bus.vga_y <= sum_y[7:0];
                pc        <= emit_pc;
                if (in_view) begin
                    bus.colour <= emit_col;
                end
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        qreg           <= bus.quantity;
                        idx            <= 4'd0;
                        bus.draw_index <= 4'd0;
                        if (bus.quantity == 4'd0) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state               <= S_ADDR;
                            bus.draw_stone_flag <= 1'b1;
                        end
                    end
                end
                S_ADDR: state <= S_WAIT;
                S_WAIT: begin
                    // RAM q is valid two edges after the address was presented.
                    cur_x    <= bus.stone_data[31:23];
                    cur_y    <= bus.stone_data[18:11];
                    cur_type <= bus.stone_data[3:2];
                    cur_vis  <= bus.stone_data[1];
                    state    <= S_LATCH;
                end
                S_LATCH: begin
                    if (erase_needed) begin
                        state <= S_ERASE;
                    end else if (cur_vis) begin
                        state <= S_DRAW;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_ERASE: begin
                    if (pc == 8'hFF) begin
                        sh_v[idx] <= 1'b0;
                        state     <= cur_vis ? S_DRAW : S_NEXT;
                    end
                end
                S_DRAW: begin
                    if (pc == 8'hFF) begin
                        sh_v[idx] <= 1'b1;
                        sh_x[idx] <= cur_x;
                        sh_y[idx] <= cur_y;
                        state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    idx <= idx + 4'd1;
                    if (idx + 4'd1 == qreg) begin
                        state               <= S_DONE;
                        bus.draw_stone_flag <= 1'b0;
                        bus.done            <= 1'b1;
                    end else begin
                        bus.draw_index <= idx + 4'd1;
                        state          <= S_ADDR;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stone_drawer.sv
// Scoreboard bench: a box-level model predicts every pixel (with its cycle) and the done time per pass.
module tb_stone_drawer;

    localparam int COL_STONE   = 9'b100_100_100;
    localparam int COL_GOLD    = 9'b111_110_000;
    localparam int COL_DIAMOND = 9'b000_111_111;
    localparam int COL_BG      = 9'b011_010_001;

    typedef struct {
        int t;
        int x;
        int y;
        int col;
    } pix_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    stone_drawer_if bus ();

    stone_drawer dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [31:0] ram [16];
    int mx [16];
    int my [16];
    int mt [16];
    int mv [16];
    bit sv [16];
    int sx [16];
    int sy [16];

    pix_t exp_q [$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   start_cyc = 0;

    always @(posedge clock) bus.stone_data <= ram[bus.draw_index];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int colour_of(input int t);
        if (t == 0) return COL_STONE;
        if (t == 1) return COL_GOLD;
        return COL_DIAMOND;
    endfunction

    task automatic set_entry(input int i, input int x, input int y, input int t, input int v);
        mx[i] = x; my[i] = y; mt[i] = t; mv[i] = v;
        ram[i] = {x[8:0], 4'($urandom), y[7:0], 7'($urandom), t[1:0], v[0], 1'($urandom)};
    endtask

    task automatic push_box(input int t0, input int bx, input int by, input int col);
        for (int k = 0; k < 256; k++) begin
            int x = bx + k % 16;
            int y = by + k / 16;
            if (x < 320 && y < 240) exp_q.push_back('{t0 + 1 + k, x, y, col});
        end
    endtask

    // Walks the table as the pass would, updating the model's record of drawn boxes.
    task automatic predict(input int q, output int done_at);
        int t = 0;
        for (int i = 0; i < q; i++) begin
            bit er = sv[i] && (mv[i] == 0 || sx[i] != mx[i] || sy[i] != my[i]);
            t += 3;
            if (er) begin
                push_box(t, sx[i], sy[i], COL_BG);
                t += 256;
                sv[i] = 0;
            end
            if (mv[i] != 0) begin
                push_box(t, mx[i], my[i], colour_of(mt[i]));
                t += 256;
                sv[i] = 1; sx[i] = mx[i]; sy[i] = my[i];
            end
            t += 1;
        end
        done_at = t + 1;
    endtask

    always @(negedge clock) begin
        pix_t e;
        cyc++;
        if (resetn && bus.plot) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL plot_unexpected actual=(%0d,%0d,%0h) required=none",
                         bus.vga_x, bus.vga_y, bus.colour);
            end else begin
                e = exp_q.pop_front();
                if (cyc - start_cyc != e.t || int'(bus.vga_x) != e.x ||
                    int'(bus.vga_y) != e.y || int'(bus.colour) != e.col) begin
                    errors++;
                    $display("FAIL pixel actual=t%0d (%0d,%0d,%0h) required=t%0d (%0d,%0d,%0h)",
                             cyc - start_cyc, bus.vga_x, bus.vga_y, bus.colour,
                             e.t, e.x, e.y, e.col);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_plot"},  int'(bus.plot), 0);
        check({tag, "_x"},     int'(bus.vga_x), 0);
        check({tag, "_y"},     int'(bus.vga_y), 0);
        check({tag, "_col"},   int'(bus.colour), 0);
        check({tag, "_done"},  int'(bus.done), 0);
        check({tag, "_flag"},  int'(bus.draw_stone_flag), 0);
        check({tag, "_index"}, int'(bus.draw_index), 0);
    endtask

    task automatic run_pass(input int q, input string name);
        int exp_n;
        int n = 0;
        bit seen = 0;
        predict(q, exp_n);
        @(negedge clock);
        bus.quantity = q[3:0];
        bus.start    = 1'b1;
        @(posedge clock);
        start_cyc = cyc;
        #1 bus.start = 1'b0;
        while (!seen && n < 9000) begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                check({name, "_flag_rise"}, int'(bus.draw_stone_flag), int'(q != 0));
                check({name, "_index0"}, int'(bus.draw_index), 0);
            end
            if (n == 2) begin
                bus.start    = 1'b1;
                bus.quantity = ~q[3:0];
            end
            if (n == 3) begin
                bus.start    = 1'b0;
                bus.quantity = q[3:0];
            end
            if (bus.done) seen = 1;
        end
        check({name, "_done_cycle"}, n, exp_n);
        check({name, "_flag_at_done"}, int'(bus.draw_stone_flag), 0);
        bus.start = 1'b1;
        @(negedge clock);
        check({name, "_done_width"}, int'(bus.done), 0);
        bus.start = 1'b0;
        @(negedge clock);
        check({name, "_start_in_done"}, int'(bus.draw_stone_flag), 0);
        #1;
        check({name, "_leftover"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int dummy;
        bus.start    = 1'b0;
        bus.quantity = 4'd0;
        for (int i = 0; i < 16; i++) begin
            set_entry(i, 0, 0, 0, 0);
            sv[i] = 0; sx[i] = 0; sy[i] = 0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_idle_outputs("reset");
        resetn = 1'b1;

        set_entry(0, 100, 50, 1, 1);
        run_pass(1, "gold_first");
        run_pass(1, "gold_again");
        set_entry(0, 104, 40, 1, 1);
        run_pass(1, "gold_moved");
        set_entry(0, 104, 40, 1, 0);
        run_pass(1, "captured");
        run_pass(1, "empty");
        set_entry(0, 310, 232, 2, 1);
        run_pass(1, "clipped");
        run_pass(0, "q_zero");

        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_entry(i, $urandom_range(0, 330), $urandom_range(0, 250),
                              $urandom_range(0, 3), int'($urandom_range(0, 3) != 0));
            end
            run_pass((p == 5) ? 0 : $urandom_range(1, 6), "random");
        end

        // Abort a pass in the middle of a draw.
        set_entry(0, 200, 100, 0, 1);
        set_entry(1, 20, 20, 3, 1);
        predict(2, dummy);
        @(negedge clock);
        bus.quantity = 4'd2;
        bus.start    = 1'b1;
        @(posedge clock);
        start_cyc = cyc;
        #1 bus.start = 1'b0;
        repeat (300) @(negedge clock);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        for (int i = 0; i < 16; i++) sv[i] = 0;
        @(negedge clock);
        resetn = 1'b1;
        set_entry(0, 60, 70, 0, 1);
        set_entry(1, 21, 20, 3, 1);
        run_pass(2, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
